// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // Debug-visible FSM encoding; 2'd3 is never entered.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_MWAIT  = 2'd2
  } ctrl_state_t;

  localparam int unsigned LOAD_STALL_CYCLES_DEF = 1;
  localparam int unsigned CNT_W_DEF             = 32;
  // Remaining-bubble counter width; holds LOAD_STALL_CYCLES-1 (max 3).
  localparam int unsigned LCNT_W                = 2;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard requests in, pipeline register controls out.
interface pipeline_hazard_ctrl_if;
  logic stall_req;
  logic flush_req;
  logic dmem_busy;
  logic pc_we;
  logic ifid_we;
  logic pipe_en;
  logic ifid_flush;
  logic idex_bubble;
  logic exmem_flush;

  // Hazard detection / datapath side
  modport master (
    output stall_req, flush_req, dmem_busy,
    input  pc_we, ifid_we, pipe_en, ifid_flush, idex_bubble, exmem_flush
  );

  // Controller side
  modport slave (
    input  stall_req, flush_req, dmem_busy,
    output pc_we, ifid_we, pipe_en, ifid_flush, idex_bubble, exmem_flush
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Clear wins; otherwise count up and stick at all-ones.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, branch flush and load-use bubbles.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = LOAD_STALL_CYCLES_DEF,
  parameter int unsigned CNT_W             = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pipeline_hazard_ctrl_if.slave    ctrl,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt,
  output logic [1:0]               state
);

  ctrl_state_t       state_q, next_state;
  logic              pend_q, next_pend;
  logic [LCNT_W-1:0] lcnt_q, next_lcnt;

  logic pc_we, ifid_we, pipe_en, ifid_flush, idex_bubble, exmem_flush;
  logic flush_now;
  logic stall_inc;
  logic cnt_clear;

  // State, pending flush and remaining-bubble register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pend_q  <= 1'b0;
      lcnt_q  <= '0;
    end else begin
      state_q <= next_state;
      pend_q  <= next_pend;
      lcnt_q  <= next_lcnt;
    end
  end

  // Priority: memory freeze > flush > load-use bubble > normal flow.
  // Encoding 3 matches no explicit branch and falls through to RUN.
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    pipe_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    flush_now   = 1'b0;
    next_state  = state_q;
    next_pend   = pend_q;
    next_lcnt   = lcnt_q;
    if (!rst_n) begin
      next_state = ST_RUN;
    end else if (ctrl.dmem_busy) begin
      next_state = ST_MWAIT;
      if (ctrl.flush_req) next_pend = 1'b1;
    end else if (ctrl.flush_req || pend_q) begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      pipe_en     = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      flush_now   = 1'b1;
      next_pend   = 1'b0;
      next_lcnt   = '0;
      next_state  = ST_RUN;
    end else if ((state_q == ST_LSTALL) ||
                 ((state_q == ST_MWAIT) && (lcnt_q != '0))) begin
      pipe_en     = 1'b1;
      idex_bubble = 1'b1;
      next_lcnt   = (lcnt_q == '0) ? '0 : lcnt_q - LCNT_W'(1);
      next_state  = (lcnt_q > LCNT_W'(1)) ? ST_LSTALL : ST_RUN;
    end else if (ctrl.stall_req) begin
      pipe_en     = 1'b1;
      idex_bubble = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        next_lcnt  = LCNT_W'(LOAD_STALL_CYCLES - 1);
        next_state = ST_LSTALL;
      end else begin
        next_state = ST_RUN;
      end
    end else begin
      pc_we      = 1'b1;
      ifid_we    = 1'b1;
      pipe_en    = 1'b1;
      next_state = ST_RUN;
    end
  end

  assign ctrl.pc_we       = pc_we;
  assign ctrl.ifid_we     = ifid_we;
  assign ctrl.pipe_en     = pipe_en;
  assign ctrl.ifid_flush  = ifid_flush;
  assign ctrl.idex_bubble = idex_bubble;
  assign ctrl.exmem_flush = exmem_flush;
  assign state            = state_q;

  assign cnt_clear = !rst_n;
  assign stall_inc = rst_n && !pc_we;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (cnt_clear),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (cnt_clear),
    .inc   (flush_now),
    .count (flush_cnt)
  );

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter LOAD_STALL_CYCLES, default 1, range 1..4; bubble cycles inserted per load-use hazard.
REQ-002 Parameter CNT_W, default 32; width of performance counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 stall_req  input  1  load-use hazard request from the hazard detection unit.
REQ-006 flush_req  input  1  taken branch resolved; squash younger instructions.
REQ-007 dmem_busy  input  1  data memory not ready; freeze the whole pipeline.
REQ-008 pc_we  output  1  PC write enable.
REQ-009 ifid_we  output  1  IF/ID register write enable.
REQ-010 pipe_en  output  1  ID/EX, EX/MEM and MEM/WB register enable.
REQ-011 ifid_flush  output  1  clear IF/ID to NOP.
REQ-012 idex_bubble  output  1  zero ID/EX control lines.
REQ-013 exmem_flush  output  1  zero EX/MEM control lines.
REQ-014 stall_cnt  output  CNT_W  cycles with pc_we=0 since reset.
REQ-015 flush_cnt  output  CNT_W  flush cycles applied since reset.
REQ-016 state  output  2  FSM state encoding, debug only.

Function
REQ-017 The FSM SHALL have states RUN=0, LSTALL=1, MWAIT=2; encoding 3 is unreachable and SHALL return to RUN.
REQ-018 Input priority SHALL be dmem_busy > flush (flush_req or pending_flush) > load stall (stall_req or LSTALL) > normal.
REQ-019 Normal: pc_we=1, ifid_we=1, pipe_en=1, ifid_flush=0, idex_bubble=0, exmem_flush=0.
REQ-020 dmem_busy=1 (any state): pc_we=0, ifid_we=0, pipe_en=0, all flush/bubble outputs 0; next state MWAIT.
REQ-021 flush_req=1 while dmem_busy=1 SHALL set pending_flush, held until applied.
REQ-022 Flush cycle: pc_we=1, ifid_we=1, pipe_en=1, ifid_flush=1, idex_bubble=1, exmem_flush=1; clears pending_flush and the load-stall counter; next state RUN.
REQ-023 A flush SHALL override a simultaneous stall_req or an active LSTALL.
REQ-024 Load stall from RUN/MWAIT: pc_we=0, ifid_we=0, pipe_en=1, idex_bubble=1; if LOAD_STALL_CYCLES>1, load counter with LOAD_STALL_CYCLES-1 and enter LSTALL.
REQ-025 LSTALL: same outputs as REQ-024 regardless of stall_req; decrement counter each non-busy cycle; at 0 return to RUN.
REQ-026 dmem_busy during LSTALL SHALL freeze the counter; LSTALL resumes after MWAIT.
REQ-027 MWAIT with dmem_busy=0: apply pending flush, else resume LSTALL if counter nonzero, else evaluate stall_req/normal; exit to the matching state.
REQ-028 Outputs SHALL be combinational from registered state and current inputs; zero-cycle response latency.
REQ-029 stall_cnt increments by 1 each cycle pc_we=0 (rst_n high), saturating at all-ones.
REQ-030 flush_cnt increments by 1 each flush cycle, saturating at all-ones.

Reset
REQ-031 While rst_n=0 at a rising edge: state=RUN, counters=0, pending_flush=0, stall counter=0.
REQ-032 While rst_n=0, all control outputs SHALL be 0 and counters SHALL not increment; reset mid-stall or mid-MWAIT discards the pending operation.

Structure
REQ-033 State enum, state encodings and default parameter values SHALL reside in shared package pipe_ctrl_pkg.
REQ-034 A parameterised saturating counter sub-module sat_counter (width, inc, clear) SHALL be instantiated twice.

Verification
REQ-035 stall_req=1 one cycle, LOAD_STALL_CYCLES=1 -> one cycle pc_we=0, ifid_we=0, idex_bubble=1; stall_cnt=1.
REQ-036 LOAD_STALL_CYCLES=3, stall_req pulse 1 cycle -> 3 consecutive bubble cycles, state 0->1->1->0, stall_cnt=3.
REQ-037 stall_req=1 and flush_req=1 same cycle -> flush outputs only, idex_bubble=1, pc_we=1, flush_cnt=1, stall_cnt=0.
REQ-038 dmem_busy=1 for 4 cycles with flush_req pulse in cycle 2 -> pipe_en=0 four cycles, flush applied in cycle 5, flush_cnt=1, stall_cnt=4.
REQ-039 CNT_W=4, 20 stall cycles -> stall_cnt holds 15.
REQ-040 rst_n=0 during LSTALL -> next cycle state=0, counters 0, normal outputs after rst_n=1.
